// File: rtl/square_accum_pkg.sv
// ---------------------------------------------------------------------------
// square_accum_pkg
//
// Shared definitions for the square accumulator control/readout slice.
//   - state_e          : window sequencer states
//   - *_DEF            : default widths and latency used by the blocks
//   - MAX_SQ_TERM      : largest single accumulator increment, 2m(m+1) at m=15
//   - max_window()     : longest window whose worst-case sum fits an
//                        accumulator of the given width
// ---------------------------------------------------------------------------
package square_accum_pkg;

    localparam int MAG_W_DEF       = 4;
    localparam int ACC_W_DEF       = 24;
    localparam int CNT_W_DEF       = 16;
    localparam int OUT_W_DEF       = 26;
    localparam int ACC_LATENCY_DEF = 3;

    // The accumulator adds 2m(m+1) per sample; with m = 15 that is 480.
    localparam int MAX_SQ_TERM = 480;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        CLR   = 3'd2,
        ARM   = 3'd3,
        RUN   = 3'd4,
        DRAIN = 3'd5,
        CAPT  = 3'd6
    } state_e;

    // floor((2^acc_w - 1) / MAX_SQ_TERM): a window of this many worst-case
    // samples still fits, so the accumulator never needs saturation.
    function automatic int max_window(input int acc_w);
        longint unsigned full;
        full = (64'd1 << acc_w) - 64'd1;
        return int'(full / 64'(MAX_SQ_TERM));
    endfunction

endpackage

// File: rtl/square_power_convert.sv
// ---------------------------------------------------------------------------
// square_power_convert
//
// Turns the raw symmetric-square accumulator value into a true power sum and
// holds it until the next capture.
//   power = 2*acc + N = sum of (2m+1)^2 = 4 * sum of (m+1/2)^2
//
// Ports
//   clk_i          system clock
//   rst_n_i        synchronous active-low reset (clears outputs)
//   capture_i      one-cycle capture request from the sequencer
//   acc_i          accumulator value, sum of 2m(m+1)
//   count_i        number of valid samples N in the window
//   power_o        registered power sum, held between captures
//   nsamp_o        registered N, held between captures
//   power_valid_o  high for the single cycle after a capture
// ---------------------------------------------------------------------------
module square_power_convert #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 16,
    parameter int OUT_W = 26
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             capture_i,
    input  logic [ACC_W-1:0] acc_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [OUT_W-1:0] power_o,
    output logic [CNT_W-1:0] nsamp_o,
    output logic             power_valid_o
);

    logic [OUT_W-1:0] power_d;

    // Zero-extend both operands before the shift so the doubled accumulator
    // keeps its top bit.
    assign power_d = (OUT_W'(acc_i) << 1) + OUT_W'(count_i);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            power_o       <= '0;
            nsamp_o       <= '0;
            power_valid_o <= 1'b0;
        end else begin
            power_valid_o <= capture_i;
            if (capture_i) begin
                power_o <= power_d;
                nsamp_o <= count_i;
            end
        end
    end

endmodule

// File: rtl/square_accum_window_reader.sv
// ---------------------------------------------------------------------------
// square_accum_window_reader
//
// Control and readout end of the 5-bit symmetric square accumulator. It
// sequences the accumulator clear/enable around an integration window of L
// valid samples, gates magnitudes into the accumulator, waits for the
// accumulator pipeline to drain and then reports the power sum.
//
// Stream semantics: mag_i is consumed only in RUN and only on cycles where
// mag_valid_i is high; there is no back-pressure, so a valid sample presented
// in RUN is always taken. power_valid_o is a one-cycle strobe with no ready;
// power_o/nsamp_o stay stable until the next capture.
//
// Ports
//   clk_i          system clock
//   rst_n_i        synchronous active-low reset
//   start_i        start pulse, looked at only in IDLE
//   cont_i         continuous mode, looked at in CAPT
//   window_len_i   valid samples per window, clamped to 1..MAX_WINDOW
//   mag_i          sample magnitude m (sample value is +/-(m+1/2))
//   mag_valid_i    qualifier for mag_i
//   acc_in_o       magnitude driven to the accumulator
//   acc_ce_o       accumulator clock enable
//   acc_rst_o      accumulator clear, active high
//   acc_i          accumulator output, sum of 2m(m+1)
//   power_o        power sum 2*acc + N
//   nsamp_o        N, valid samples in the reported window
//   power_valid_o  one-cycle strobe on update of power_o/nsamp_o
//   busy_o         high in every state except IDLE
//   state_o        current sequencer state (debug)
// ---------------------------------------------------------------------------
module square_accum_window_reader
    import square_accum_pkg::*;
#(
    parameter int MAG_W       = MAG_W_DEF,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int ACC_LATENCY = ACC_LATENCY_DEF,
    parameter int MAX_WINDOW  = max_window(ACC_W_DEF),
    parameter int OUT_W       = OUT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic [CNT_W-1:0] window_len_i,
    input  logic [MAG_W-1:0] mag_i,
    input  logic             mag_valid_i,
    output logic [MAG_W-1:0] acc_in_o,
    output logic             acc_ce_o,
    output logic             acc_rst_o,
    input  logic [ACC_W-1:0] acc_i,
    output logic [OUT_W-1:0] power_o,
    output logic [CNT_W-1:0] nsamp_o,
    output logic             power_valid_o,
    output logic             busy_o,
    output state_e           state_o
);

    localparam int DRAIN_W = (ACC_LATENCY < 2) ? 1 : $clog2(ACC_LATENCY + 1);

    localparam logic [CNT_W-1:0]   MAX_WIN_C  = CNT_W'(MAX_WINDOW);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ACC_LATENCY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic [CNT_W-1:0]   len_clamped;
    logic [CNT_W-1:0]   count_inc;
    logic               capture;

    // Zero-length windows make no sense, and anything past MAX_WINDOW could
    // overflow the accumulator, so the latched length is forced into range.
    always_comb begin
        len_clamped = window_len_i;
        if (window_len_i == '0) begin
            len_clamped = CNT_W'(1);
        end else if (window_len_i > MAX_WIN_C) begin
            len_clamped = MAX_WIN_C;
        end
    end

    assign count_inc = count_q + CNT_W'(1);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            drain_q <= drain_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        drain_d   = drain_q;
        acc_in_o  = '0;
        acc_ce_o  = 1'b0;
        acc_rst_o = 1'b0;
        capture   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d   = len_clamped;
                    state_d = HOLD;
                end
            end

            HOLD: begin
                state_d = CLR;
            end

            CLR: begin
                acc_rst_o = 1'b1;
                state_d   = ARM;
            end

            ARM: begin
                count_d = '0;
                state_d = RUN;
            end

            RUN: begin
                acc_ce_o = 1'b1;
                if (mag_valid_i) begin
                    acc_in_o = mag_i;
                    count_d  = count_inc;
                    // Leave on the very cycle the L-th sample is taken so no
                    // extra sample can slip into the window.
                    if (count_inc == len_q) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Keep the accumulator clocked with zero input so the last
                // samples ripple through its pipeline.
                acc_ce_o = 1'b1;
                drain_d  = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_LAST) begin
                    state_d = CAPT;
                end
            end

            CAPT: begin
                acc_ce_o = 1'b1;
                capture  = 1'b1;
                state_d  = cont_i ? HOLD : IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign state_o = state_q;

    square_power_convert #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W),
        .OUT_W (OUT_W)
    ) u_convert (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .capture_i     (capture),
        .acc_i         (acc_i),
        .count_i       (count_q),
        .power_o       (power_o),
        .nsamp_o       (nsamp_o),
        .power_valid_o (power_valid_o)
    );

endmodule

// File: tb/tb_square_accum_window_reader.sv
// ---------------------------------------------------------------------------
// tb_square_accum_window_reader
//
// Drives windows of random and directed magnitudes. A model of the external
// accumulator (3-cycle latency, adds 2m(m+1)) closes the loop. The expected
// power is computed as the sum of (2m+1)^2 over the samples accepted in RUN,
// pushed into a queue, and a monitor compares each strobe.
// ---------------------------------------------------------------------------
module tb_square_accum_window_reader;
    import square_accum_pkg::*;

    localparam int MAG_W       = 4;
    localparam int ACC_W       = 24;
    localparam int CNT_W       = 16;
    localparam int OUT_W       = 26;
    localparam int ACC_LATENCY = 3;
    localparam int MAX_WIN     = 34952;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic             start_i = 1'b0;
    logic             cont_i = 1'b0;
    logic [CNT_W-1:0] window_len_i = '0;
    logic [MAG_W-1:0] mag_i = '0;
    logic             mag_valid_i = 1'b0;
    logic [MAG_W-1:0] acc_in_o;
    logic             acc_ce_o;
    logic             acc_rst_o;
    logic [ACC_W-1:0] acc_i;
    logic [OUT_W-1:0] power_o;
    logic [CNT_W-1:0] nsamp_o;
    logic             power_valid_o;
    logic             busy_o;
    state_e           state_o;

    square_accum_window_reader dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .start_i       (start_i),
        .cont_i        (cont_i),
        .window_len_i  (window_len_i),
        .mag_i         (mag_i),
        .mag_valid_i   (mag_valid_i),
        .acc_in_o      (acc_in_o),
        .acc_ce_o      (acc_ce_o),
        .acc_rst_o     (acc_rst_o),
        .acc_i         (acc_i),
        .power_o       (power_o),
        .nsamp_o       (nsamp_o),
        .power_valid_o (power_valid_o),
        .busy_o        (busy_o),
        .state_o       (state_o)
    );

    // ---------------- external accumulator model ----------------
    // Not tied to rst_n_i: only its own clear input empties it.
    logic [ACC_W-1:0] st1 = '0, st2 = '0, acc_q = '0;

    function automatic logic [ACC_W-1:0] acc_term(input logic [MAG_W-1:0] m);
        int mi;
        mi = int'(m);
        return ACC_W'(2 * mi * (mi + 1));
    endfunction

    always @(posedge clk_i) begin
        if (acc_rst_o) begin
            st1   <= '0;
            st2   <= '0;
            acc_q <= '0;
        end else if (acc_ce_o) begin
            st1   <= acc_term(acc_in_o);
            st2   <= st1;
            acc_q <= acc_q + st2;
        end
    end
    assign acc_i = acc_q;

    // ---------------- scoreboard ----------------
    logic [OUT_W-1:0] exp_q[$];
    logic [CNT_W-1:0] exp_n_q[$];
    int               exp_t_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding window.
    always @(negedge clk_i) begin
        if (rst_n_i && power_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got power %0d nsamp %0d with nothing expected (cycle %0d)",
                         power_o, nsamp_o, cyc);
            end else begin
                check("power", 32'(power_o), 32'(exp_q.pop_front()));
                check("nsamp", 32'(nsamp_o), 32'(exp_n_q.pop_front()));
                check("strobe_cycle", 32'(cyc), 32'(exp_t_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Random traffic on inputs that must be ignored in the current state.
    task automatic garbage();
        mag_i       = MAG_W'($urandom_range(0, 15));
        mag_valid_i = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy_o || exp_q.size() != 0) && n < 200) begin
            garbage();
            step();
            n++;
        end
        check(name, 32'(busy_o || exp_q.size() != 0), 32'd0);
    endtask

    // Pulse start from IDLE and walk through HOLD/CLR/ARM; returns with
    // the inputs about to be sampled in the first RUN cycle.
    task automatic start_window(input int len, input bit cont);
        start_i      = 1'b1;
        cont_i       = cont;
        window_len_i = CNT_W'(len);
        garbage();
        step();
        start_i      = 1'b0;
        window_len_i = CNT_W'($urandom_range(0, 65535));
        for (int i = 0; i < 3; i++) begin
            garbage();
            step();
        end
    endtask

    // Drive samples in RUN until eff_len valid ones have been accepted.
    // mode 0: random m, 1: ramp m = 1,2,..., 2: constant fixed_m.
    // gap_at >= 0 forces three invalid cycles before that sample index.
    task automatic drive_window(input int eff_len, input int mode, input int fixed_m,
                                input int gap_pct, input int gap_at);
        int cnt, last, gaps;
        longint sum;
        logic [MAG_W-1:0] m;
        bit v;
        cnt  = 0;
        sum  = 0;
        last = 0;
        gaps = 0;
        while (cnt < eff_len) begin
            case (mode)
                0:       m = MAG_W'($urandom_range(0, 15));
                1:       m = MAG_W'(cnt + 1);
                default: m = MAG_W'(fixed_m);
            endcase
            v = ($urandom_range(0, 99) >= gap_pct);
            if (cnt == gap_at && gaps < 3) begin
                v = 1'b0;
                gaps++;
                m = MAG_W'($urandom_range(0, 15));
            end
            mag_i       = m;
            mag_valid_i = v;
            if (v) begin
                cnt++;
                sum += longint'((2 * int'(m) + 1) * (2 * int'(m) + 1));
                last = cyc;
            end
            step();
        end
        exp_q.push_back(OUT_W'(sum));
        exp_n_q.push_back(CNT_W'(cnt));
        exp_t_q.push_back(last + ACC_LATENCY + 2);
        garbage();
    endtask

    // Continuous mode: drain + CAPT + HOLD/CLR/ARM after the last sample.
    task automatic dead_time();
        for (int i = 0; i < ACC_LATENCY + 4; i++) begin
            garbage();
            step();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int len;
        garbage();
        for (int i = 0; i < 4; i++) step();

        check("rst_state", 32'(state_o), 32'(IDLE));
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_power", 32'(power_o), 32'd0);
        check("rst_nsamp", 32'(nsamp_o), 32'd0);
        check("rst_valid", 32'(power_valid_o), 32'd0);
        check("rst_ce", 32'(acc_ce_o), 32'd0);
        check("rst_acc_rst", 32'(acc_rst_o), 32'd0);

        rst_n_i = 1'b1;
        mag_i = 4'd9;
        mag_valid_i = 1'b1;
        step();
        check("idle_acc_in", 32'(acc_in_o), 32'd0);
        check("idle_ce", 32'(acc_ce_o), 32'd0);

        // Single samples: m=3 -> 49, m=15 -> 961, m=0 -> 1.
        start_window(1, 0); drive_window(1, 2, 3, 0, -1);  wait_idle("idle_m3");
        start_window(1, 0); drive_window(1, 2, 15, 0, -1); wait_idle("idle_m15");
        start_window(1, 0); drive_window(1, 2, 0, 0, -1);  wait_idle("idle_m0");

        // Ramp 1..15 -> 5455.
        start_window(15, 0); drive_window(15, 1, 0, 0, -1); wait_idle("idle_ramp");

        // L=4, m=2, three-cycle gap mid-window -> 100.
        start_window(4, 0); drive_window(4, 2, 2, 0, 2); wait_idle("idle_gap");

        // window_len_i = 0 behaves as L = 1.
        start_window(0, 0); drive_window(1, 2, 3, 20, -1); wait_idle("idle_len0");

        // Random windows with random gaps.
        for (int w = 0; w < 6; w++) begin
            len = $urandom_range(1, 20);
            start_window(len, 0);
            drive_window(len, 0, 0, 30, -1);
            wait_idle("idle_rand");
        end

        // Oversized length clamps to MAX_WINDOW.
        start_window(65535, 0); drive_window(MAX_WIN, 0, 0, 0, -1); wait_idle("idle_max");

        // Continuous mode, m=1, L=8 -> 72 each window.
        start_window(8, 1);
        drive_window(8, 2, 1, 0, -1);
        dead_time();
        drive_window(8, 2, 1, 0, -1);
        dead_time();
        // Third window is cut short by reset while in RUN.
        for (int i = 0; i < 3; i++) begin
            mag_i = 4'd1;
            mag_valid_i = 1'b1;
            step();
        end
        check("pre_reset_state", 32'(state_o), 32'(RUN));
        rst_n_i = 1'b0;
        cont_i  = 1'b0;
        step();
        rst_n_i = 1'b1;
        check("midrun_state", 32'(state_o), 32'(IDLE));
        check("midrun_busy", 32'(busy_o), 32'd0);
        check("midrun_power", 32'(power_o), 32'd0);
        check("midrun_nsamp", 32'(nsamp_o), 32'd0);
        check("midrun_valid", 32'(power_valid_o), 32'd0);
        for (int i = 0; i < 20; i++) begin
            garbage();
            step();
        end
        check("post_reset_busy", 32'(busy_o), 32'd0);

        // Next start must clear the partial sum left in the accumulator.
        start_window(3, 0); drive_window(3, 0, 0, 10, -1); wait_idle("idle_after_rst");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/square_accum_window_reader.md
Name: square_accum_window_reader

Overview:
- Control and readout end of the 5-bit symmetric square accumulator.
- Sequences accumulator clock-enable and reset around a programmable integration window, and gates incoming magnitudes into the accumulator.
- After the pipeline drains, converts the raw accumulator value into a true power sum and presents it with a one-cycle valid strobe.
- Sits between the sample magnitude stream and the trigger/monitor logic.

Parameters:
- MAG_W, 4: width of the sample magnitude m (symmetric rep; the sample value is ±(m+½)).
- ACC_W, 24: accumulator width.
- CNT_W, 16: window length and sample counter width.
- ACC_LATENCY, 3: cycles from acc_in_o to its contribution appearing on acc_i.
- MAX_WINDOW, 34952: largest window that cannot overflow ACC_W, equal to floor((2^24-1)/480).
- OUT_W, 26: power output width.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  synchronous, active-low reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- cont_i  in  1  continuous mode; sampled at CAPT.
- window_len_i  in  CNT_W  number of valid samples per window; latched on start.
- mag_i  in  MAG_W  sample magnitude m.
- mag_valid_i  in  1  mag_i qualifier.
- acc_in_o  out  MAG_W  magnitude driven to the accumulator.
- acc_ce_o  out  1  accumulator clock enable.
- acc_rst_o  out  1  accumulator reset, active high.
- acc_i  in  ACC_W  accumulator output; contract: acc_i = Σ 2m(m+1).
- power_o  out  OUT_W  power sum = 2·acc_i + N = Σ(2m+1)², i.e. 4·Σ(m+½)².
- nsamp_o  out  CNT_W  N, the number of valid samples in the reported window.
- power_valid_o  out  1  one-cycle strobe when power_o/nsamp_o update.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n_i=0 at a clock edge) forces:
  - state to IDLE;
  - acc_ce_o=0, acc_rst_o=0, acc_in_o=0;
  - power_o=0, nsamp_o=0, power_valid_o=0, busy_o=0, internal counters 0.
  - Reset mid-window abandons the window with no strobe; the next start clears the accumulator.
- FSM states and transitions:
  - IDLE: ce=0. On start_i=1, latch the window length as L = clamp(window_len_i, 1, MAX_WINDOW); 0 maps to 1. Go to HOLD.
  - HOLD (1 cycle): ce=0, rst=0.
  - CLR (1 cycle): ce=0, rst=1.
  - ARM (1 cycle): ce=0, rst=0; sample counter cleared.
  - RUN: ce=1.
    - acc_in_o = mag_valid_i ? mag_i : 0, combinational from the inputs.
    - Counter increments on each valid sample.
    - On the cycle the L-th valid sample is accepted, go to DRAIN.
    - Invalid cycles feed 0 and do not count.
  - DRAIN: ce=1, acc_in_o=0 for exactly ACC_LATENCY cycles, then go to CAPT.
  - CAPT (1 cycle): ce=1, acc_in_o=0.
    - Register power_o = (acc_i<<1) + count, zero-extended to OUT_W, and nsamp_o = count.
    - power_valid_o is high the following cycle.
    - Then go to HOLD if cont_i=1, else IDLE.
- Inputs ignored outside their state: start_i is ignored when not in IDLE; mag_i/mag_valid_i are ignored outside RUN.
- Latency:
  - Last accepted sample to power_valid_o = ACC_LATENCY+2 cycles.
  - In continuous mode, windows repeat with a 3-cycle dead time (HOLD/CLR/ARM) plus drain; samples during dead time are discarded.
- power_o/nsamp_o hold their values until the next CAPT.
- With the MAX_WINDOW clamp, the accumulator cannot overflow; no saturation logic.

Decomposition:
- Shared package square_accum_pkg:
  - state enum (IDLE, HOLD, CLR, ARM, RUN, DRAIN, CAPT);
  - MAG_W, ACC_W defaults;
  - MAX_SQ_TERM = 480;
  - the MAX_WINDOW derivation function.
- One natural sub-module: square_power_convert, the registered 2·acc+N adder and output latch.

Test Plan:
- Single sample: start, L=1, m=3 → power_o=49, nsamp_o=1 (acc_i=24); strobe ACC_LATENCY+2 cycles after the sample.
- Single sample m=15, then separately m=0 (each L=1) → power_o=961, then power_o=1.
- Ramp m=1..15 with L=15 → power_o=5455, nsamp_o=15.
- L=4, m=2 each, mag_valid_i dropped for 3 cycles mid-window → power_o=100, nsamp_o=4; gaps are not counted.
- Edge cases:
  - window_len_i=0 → behaves as L=1;
  - window_len_i=65535 → nsamp_o=34952.
- cont_i=1 with m=1 constant, L=8 → repeated strobes with power_o=72; then rst_n_i=0 mid-RUN → outputs 0, no strobe, FSM in IDLE.
